// File: rtl/rns2bin_seq.sv
// rns2bin_seq: sequential CRT converter from one-hot RNS lanes to binary.
// One lane's precomputed weight is folded into a mod-M accumulator per cycle,
// with valid/ready handshakes on both sides, optional symmetric signed output
// and one-hot error detection on the captured word.
module rns2bin_seq #(
    parameter int unsigned        N_MOD = 7,
    parameter int unsigned        MAXM  = 17,
    parameter logic [N_MOD*8-1:0] MODS  = {8'd17, 8'd13, 8'd11, 8'd7, 8'd5, 8'd9, 8'd8},
    parameter int unsigned        OUT_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_MOD*MAXM-1:0]  x,
    input  logic                   mode_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       y,
    output logic                   err
);

    localparam int unsigned XW = N_MOD * MAXM;
    localparam int unsigned CW = (N_MOD > 1) ? $clog2(N_MOD) : 1;
    localparam int unsigned TW = N_MOD * MAXM * OUT_W;

    // Modulus of lane i (8 bits per lane, lane 0 in the low byte).
    function automatic int unsigned mod_of(input int unsigned i);
        return 32'(MODS[i*8 +: 8]);
    endfunction

    // Dynamic range M = product of all moduli.
    function automatic longint unsigned calc_m();
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < N_MOD; i++) begin
            p = p * 64'(mod_of(i));
        end
        return p;
    endfunction

    localparam longint unsigned M    = calc_m();
    localparam longint unsigned HALF = (M + 1) / 2;

    // CRT basis B_i = (M/m_i) * inv(M/m_i mod m_i) mod M.
    function automatic longint unsigned crt_basis(input int unsigned i);
        longint unsigned mi;
        longint unsigned q;
        longint unsigned r;
        longint unsigned inv;
        mi  = 64'(mod_of(i));
        q   = M / mi;
        r   = q % mi;
        inv = 0;
        for (longint unsigned t = 1; t < mi; t++) begin
            if (((r * t) % mi) == 1) begin
                inv = t;
            end
        end
        return (q * inv) % M;
    endfunction

    // Flat weight table: entry (lane i, bit k) holds k*B_i mod M.
    function automatic logic [TW-1:0] build_table();
        logic [TW-1:0]   t;
        longint unsigned b;
        t = '0;
        for (int unsigned i = 0; i < N_MOD; i++) begin
            b = crt_basis(i);
            for (int unsigned k = 0; k < MAXM; k++) begin
                t[(i*MAXM + k)*OUT_W +: OUT_W] = OUT_W'((64'(k) * b) % M);
            end
        end
        return t;
    endfunction

    // A word is bad if any lane is not exactly one-hot inside its modulus.
    function automatic logic word_bad(input logic [XW-1:0] w);
        logic        bad;
        int unsigned ones;
        bad = 1'b0;
        for (int unsigned i = 0; i < N_MOD; i++) begin
            ones = 0;
            for (int unsigned k = 0; k < MAXM; k++) begin
                if (w[i*MAXM + k]) begin
                    ones = ones + 1;
                    if (k >= mod_of(i)) begin
                        bad = 1'b1;
                    end
                end
            end
            if (ones != 1) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    localparam logic [TW-1:0]    WTAB   = build_table();
    localparam logic [OUT_W:0]   M_S    = (OUT_W+1)'(M);
    localparam logic [OUT_W-1:0] M_O    = OUT_W'(M);
    localparam logic [OUT_W-1:0] HALF_O = OUT_W'(HALF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIX   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [XW-1:0]    xq;
    logic             mode_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] acc;

    int unsigned      lane_base_c;
    logic [MAXM-1:0]  lane_c;
    logic [OUT_W-1:0] term_c;
    logic [OUT_W:0]   sum_c;
    logic [OUT_W-1:0] acc_next_c;
    logic [OUT_W-1:0] y_fix_c;
    logic             bad_c;

    // Weight lookup for the current lane, modular add and signed remap.
    always_comb begin
        lane_base_c = 32'(cnt) * MAXM;
        lane_c      = xq[lane_base_c +: MAXM];
        term_c      = '0;
        for (int unsigned k = 0; k < MAXM; k++) begin
            if (lane_c[k]) begin
                term_c = term_c | WTAB[(lane_base_c + k)*OUT_W +: OUT_W];
            end
        end
        sum_c      = {1'b0, acc} + {1'b0, term_c};
        acc_next_c = (sum_c >= M_S) ? OUT_W'(sum_c - M_S) : sum_c[OUT_W-1:0];
        if (err_q) begin
            y_fix_c = '0;
        end else if (mode_q && (acc >= HALF_O)) begin
            y_fix_c = acc - M_O;
        end else begin
            y_fix_c = acc;
        end
        bad_c = word_bad(x);
    end

    // Control FSM with registered handshake outputs; y settles one cycle
    // before out_valid rises and is held until the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            err       <= 1'b0;
            xq        <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xq       <= x;
                        mode_q   <= mode_signed;
                        err_q    <= bad_c;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ACCUM;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_next_c;
                    if (cnt == CW'(N_MOD - 1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    y     <= y_fix_c;
                    err   <= err_q;
                    state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
